// File: rtl/uart_autobaud_detector_if.sv
// Serial-line and result signals of the UART auto-baud detector.
// The master side drives the RX line and the arm pulse; the slave side
// (the detector) returns the detected mode and status strobes.
interface uart_autobaud_detector_if;
    logic       RX_In;
    logic       Detect_Start_In;
    logic [2:0] Baud_Rate_Mode_Out;
    logic       Mode_Valid_Out;
    logic       Busy_Out;
    logic       Done_Out;
    logic       Error_Out;

    modport master (
        output RX_In,
        output Detect_Start_In,
        input  Baud_Rate_Mode_Out,
        input  Mode_Valid_Out,
        input  Busy_Out,
        input  Done_Out,
        input  Error_Out
    );

    modport slave (
        input  RX_In,
        input  Detect_Start_In,
        output Baud_Rate_Mode_Out,
        output Mode_Valid_Out,
        output Busy_Out,
        output Done_Out,
        output Error_Out
    );
endinterface

// File: rtl/uart_autobaud_detector.sv
// UART auto-baud detector: times the first four bit pairs of a 0x55
// calibration character (five falling edges, eight bit periods) and
// classifies the resulting bit period into one of six baud-mode codes.
// Optional build macro AUTOBAUD_GLITCH_FILTER_EN inserts a 3-tap majority
// filter after the RX synchronizer so 1-clock pulses are not seen as edges.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for Detect_Start_In
// S_WAIT_EDGE | armed, waiting (no timeout) for the start-bit falling edge
// S_MEASURE   | counting clocks until the 5th falling edge or timeout
// S_CLASSIFY  | one cycle: range check and nearest-rate selection
module uart_autobaud_detector #(
    parameter int unsigned SYS_CLOCK = 100_000_000
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    uart_autobaud_detector_if.slave abd
);

    localparam logic [31:0] P_4800   = SYS_CLOCK / 4800;
    localparam logic [31:0] P_9600   = SYS_CLOCK / 9600;
    localparam logic [31:0] P_19200  = SYS_CLOCK / 19200;
    localparam logic [31:0] P_38400  = SYS_CLOCK / 38400;
    localparam logic [31:0] P_57600  = SYS_CLOCK / 57600;
    localparam logic [31:0] P_115200 = SYS_CLOCK / 115200;

    // Midpoints between adjacent nominal periods; a period equal to a
    // midpoint resolves to the slower rate (the >= compares below).
    localparam logic [31:0] TH_4800  = (P_4800  + P_9600)   / 2;
    localparam logic [31:0] TH_9600  = (P_9600  + P_19200)  / 2;
    localparam logic [31:0] TH_19200 = (P_19200 + P_38400)  / 2;
    localparam logic [31:0] TH_38400 = (P_38400 + P_57600)  / 2;
    localparam logic [31:0] TH_57600 = (P_57600 + P_115200) / 2;

    localparam logic [31:0] MIN_PERIOD = P_115200 - P_115200 / 8;
    localparam logic [31:0] MAX_PERIOD = P_4800 + P_4800 / 8;
    localparam logic [31:0] TIMEOUT    = 9 * P_4800;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_EDGE = 2'd1,
        S_MEASURE   = 2'd2,
        S_CLASSIFY  = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] span, span_next, span_inc;
    logic [2:0]  edge_cnt, edge_cnt_next;
    logic [2:0]  mode_q, mode_next, mode_sel;
    logic        valid_q, valid_next;
    logic        done_q, done_next;
    logic        error_q, error_next;
    logic [31:0] period;
    logic        rx_fall;

    logic rx_meta, rx_sync, rx_d1;

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic rx_d2, rx_filt, filt_prev;

    // Synchronizer plus two history taps feeding the majority vote.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_d1     <= 1'b1;
            rx_d2     <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            rx_meta   <= abd.RX_In;
            rx_sync   <= rx_meta;
            rx_d1     <= rx_sync;
            rx_d2     <= rx_d1;
            filt_prev <= rx_filt;
        end
    end

    assign rx_filt = (rx_sync & rx_d1) | (rx_sync & rx_d2) | (rx_d1 & rx_d2);
    assign rx_fall = filt_prev & ~rx_filt;
`else
    // Two-flop synchronizer plus one delay tap for edge detection.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_d1   <= 1'b1;
        end else begin
            rx_meta <= abd.RX_In;
            rx_sync <= rx_meta;
            rx_d1   <= rx_sync;
        end
    end

    assign rx_fall = rx_d1 & ~rx_sync;
`endif

    // Bit period is one eighth of the measured span; map it to a mode code.
    always_comb begin
        period = {3'b000, span[31:3]};
        if (period >= TH_4800)       mode_sel = 3'b000;
        else if (period >= TH_9600)  mode_sel = 3'b001;
        else if (period >= TH_19200) mode_sel = 3'b010;
        else if (period >= TH_38400) mode_sel = 3'b011;
        else if (period >= TH_57600) mode_sel = 3'b100;
        else                         mode_sel = 3'b101;
    end

    // FSM and result registers.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state    <= S_IDLE;
            span     <= '0;
            edge_cnt <= '0;
            mode_q   <= 3'b101;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state    <= state_next;
            span     <= span_next;
            edge_cnt <= edge_cnt_next;
            mode_q   <= mode_next;
            valid_q  <= valid_next;
            done_q   <= done_next;
            error_q  <= error_next;
        end
    end

    // Next-state logic; the timeout check precedes the edge check so a
    // coincident edge cannot rescue a measurement that has run too long.
    always_comb begin
        state_next    = state;
        span_next     = span;
        edge_cnt_next = edge_cnt;
        mode_next     = mode_q;
        valid_next    = valid_q;
        done_next     = 1'b0;
        error_next    = 1'b0;
        span_inc      = span + 32'd1;

        case (state)
            S_IDLE: begin
                if (abd.Detect_Start_In) begin
                    valid_next = 1'b0;
                    state_next = S_WAIT_EDGE;
                end
            end
            S_WAIT_EDGE: begin
                if (rx_fall) begin
                    span_next     = '0;
                    edge_cnt_next = 3'd1;
                    state_next    = S_MEASURE;
                end
            end
            S_MEASURE: begin
                span_next = span_inc;
                if (span_inc >= TIMEOUT) begin
                    error_next = 1'b1;
                    state_next = S_IDLE;
                end else if (rx_fall) begin
                    edge_cnt_next = edge_cnt + 3'd1;
                    if (edge_cnt == 3'd4) begin
                        state_next = S_CLASSIFY;
                    end
                end
            end
            S_CLASSIFY: begin
                if ((period < MIN_PERIOD) || (period > MAX_PERIOD)) begin
                    error_next = 1'b1;
                end else begin
                    mode_next  = mode_sel;
                    valid_next = 1'b1;
                    done_next  = 1'b1;
                end
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign abd.Baud_Rate_Mode_Out = mode_q;
    assign abd.Mode_Valid_Out     = valid_q;
    assign abd.Busy_Out           = (state != S_IDLE);
    assign abd.Done_Out           = done_q;
    assign abd.Error_Out          = error_q;

endmodule

// File: tb/tb_uart_autobaud_detector.sv
// Bench for uart_autobaud_detector, run at a reduced system clock so that
// full 4800-baud frames and the timeout fit in a short simulation.
module tb_uart_autobaud_detector;

    localparam int unsigned SYS_CLOCK = 1_000_000;
`ifdef AUTOBAUD_GLITCH_FILTER_EN
    localparam int FLAG_LAT = 3;
    localparam bit FILT     = 1'b1;
`else
    localparam int FLAG_LAT = 2;
    localparam bit FILT     = 1'b0;
`endif

    logic Clk_In   = 1'b0;
    logic Reset_In = 1'b1;

    uart_autobaud_detector_if abd();

    uart_autobaud_detector #(.SYS_CLOCK(SYS_CLOCK)) dut (
        .Clk_In   (Clk_In),
        .Reset_In (Reset_In),
        .abd      (abd)
    );

    always #5 Clk_In = ~Clk_In;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int pulse_busy_cnt = 0;

    int exp_mode  = 5;
    int exp_valid = 0;

    typedef struct {
        int bit_clks;
        int exp;      // -1: error expected, else mode code
    } vec_t;

    vec_t tbl[20];

    // Counts status strobes and any strobe that overlaps Busy_Out.
    always @(negedge Clk_In) begin
        if (abd.Done_Out)  done_cnt <= done_cnt + 1;
        if (abd.Error_Out) err_cnt  <= err_cnt + 1;
        if ((abd.Done_Out || abd.Error_Out) && abd.Busy_Out)
            pulse_busy_cnt <= pulse_busy_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int nom(input int i);
        case (i)
            0: return int'(SYS_CLOCK / 4800);
            1: return int'(SYS_CLOCK / 9600);
            2: return int'(SYS_CLOCK / 19200);
            3: return int'(SYS_CLOCK / 38400);
            4: return int'(SYS_CLOCK / 57600);
            default: return int'(SYS_CLOCK / 115200);
        endcase
    endfunction

    // Reference: from the times of the falling edges the detector sees,
    // derive the outcome (-1 error, else mode code).
    function automatic int model_run(input int falls[$]);
        int span, period;
        span = falls[4] - falls[0];
        if (span >= 9 * nom(0)) return -1;
        period = span / 8;
        if (period < nom(5) - nom(5) / 8 || period > nom(0) + nom(0) / 8) return -1;
        for (int i = 0; i < 5; i++)
            if (period >= (nom(i) + nom(i + 1)) / 2) return i;
        return 5;
    endfunction

    function automatic int model_frame(input int bit_clks, input bit glitch);
        int falls[$];
        int base;
        if (glitch && !FILT) falls.push_back(0);
        base = glitch ? 1000 : 0;
        for (int k = 0; k < 5; k++) falls.push_back(base + 2 * k * bit_clks);
        return model_run(falls);
    endfunction

    task automatic arm();
        @(negedge Clk_In);
        abd.Detect_Start_In = 1'b1;
        @(negedge Clk_In);
        abd.Detect_Start_In = 1'b0;
        check("busy_after_arm", int'(abd.Busy_Out), 1);
        exp_valid = 0;
        check("valid_cleared_by_arm", int'(abd.Mode_Valid_Out), exp_valid);
    endtask

    task automatic send_bits(input int bit_clks, input int nbits);
        logic [9:0] fr;
        fr = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            abd.RX_In = fr[i];
            repeat (bit_clks) @(negedge Clk_In);
        end
        abd.RX_In = 1'b1;
    endtask

    task automatic run_case(input string name, input int bit_clks, input bit glitch, input int exp);
        int d0, e0, c;
        d0 = done_cnt;
        e0 = err_cnt;
        arm();
        if (glitch) begin
            abd.RX_In = 1'b0;
            @(negedge Clk_In);
            abd.RX_In = 1'b1;
            repeat (999) @(negedge Clk_In);
        end
        send_bits(bit_clks, 10);
        c = 0;
        while (abd.Busy_Out && c < 3000) begin
            @(negedge Clk_In);
            c++;
        end
        check({name, "_idle"}, int'(abd.Busy_Out), 0);
        repeat (4) @(negedge Clk_In);
        if (exp >= 0) begin
            exp_mode  = exp;
            exp_valid = 1;
        end
        check({name, "_done_cnt"}, done_cnt - d0, (exp >= 0) ? 1 : 0);
        check({name, "_err_cnt"}, err_cnt - e0, (exp >= 0) ? 0 : 1);
        check({name, "_mode"}, int'(abd.Baud_Rate_Mode_Out), exp_mode);
        check({name, "_valid"}, int'(abd.Mode_Valid_Out), exp_valid);
    endtask

    initial begin
        int d0, e0, c, bc, exp;
        bit g;

        tbl = '{'{104, 1}, '{8, 5}, '{208, 0}, '{17, 4}, '{26, 3},
                '{52, 2}, '{6, -1}, '{7, 5}, '{233, 0}, '{234, -1},
                '{156, 0}, '{155, 1}, '{78, 1}, '{77, 2}, '{39, 2},
                '{38, 3}, '{21, 3}, '{20, 4}, '{12, 4}, '{11, 5}};

        abd.RX_In = 1'b1;
        abd.Detect_Start_In = 1'b0;
        repeat (3) @(negedge Clk_In);
        check("rst_mode", int'(abd.Baud_Rate_Mode_Out), 5);
        check("rst_valid", int'(abd.Mode_Valid_Out), 0);
        check("rst_busy", int'(abd.Busy_Out), 0);
        check("rst_done", int'(abd.Done_Out), 0);
        check("rst_error", int'(abd.Error_Out), 0);
        Reset_In = 1'b0;
        repeat (5) @(negedge Clk_In);

        for (int i = 0; i < 20; i++) begin
            run_case($sformatf("tbl%0d_bc%0d", i, tbl[i].bit_clks), tbl[i].bit_clks, 1'b0, tbl[i].exp);
            // the table constants must agree with the reference model
            check($sformatf("tbl%0d_model", i), model_frame(tbl[i].bit_clks, 1'b0), tbl[i].exp);
        end

        run_case("glitch_9600", 104, 1'b1, FILT ? 1 : 0);

        for (int i = 0; i < 10; i++) begin
            bc  = $urandom_range(240, 6);
            g   = ($urandom_range(3, 0) == 0);
            exp = model_frame(bc, g);
            run_case($sformatf("rnd%0d_bc%0d_g%0d", i, bc, g), bc, g, exp);
        end

        // Single edge then RX held low: timeout counted from the flagged edge.
        d0 = done_cnt;
        e0 = err_cnt;
        arm();
        abd.RX_In = 1'b0;
        c = 0;
        while (c < 2500) begin
            @(negedge Clk_In);
            c++;
            if (abd.Error_Out) break;
        end
        check("timeout_latency", c, 9 * nom(0) + FLAG_LAT + 1);
        check("timeout_busy", int'(abd.Busy_Out), 0);
        repeat (3) @(negedge Clk_In);
        check("timeout_err_cnt", err_cnt - e0, 1);
        check("timeout_done_cnt", done_cnt - d0, 0);
        check("timeout_mode", int'(abd.Baud_Rate_Mode_Out), exp_mode);
        check("timeout_valid", int'(abd.Mode_Valid_Out), 0);
        abd.RX_In = 1'b1;
        repeat (10) @(negedge Clk_In);

        // Reset after the third edge of a measurement.
        run_case("pre_reset", 104, 1'b0, 1);
        d0 = done_cnt;
        e0 = err_cnt;
        arm();
        for (int i = 0; i < 5; i++) begin
            abd.RX_In = (i % 2 == 1) ? 1'b1 : 1'b0;
            repeat (17) @(negedge Clk_In);
        end
        check("mid_busy", int'(abd.Busy_Out), 1);
        #2 Reset_In = 1'b1;
        #1;
        check("mid_rst_mode", int'(abd.Baud_Rate_Mode_Out), 5);
        check("mid_rst_valid", int'(abd.Mode_Valid_Out), 0);
        check("mid_rst_busy", int'(abd.Busy_Out), 0);
        check("mid_rst_done", int'(abd.Done_Out), 0);
        check("mid_rst_error", int'(abd.Error_Out), 0);
        abd.RX_In = 1'b1;
        repeat (3) @(negedge Clk_In);
        Reset_In = 1'b0;
        repeat (5) @(negedge Clk_In);
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_no_err", err_cnt - e0, 0);
        exp_mode  = 5;
        exp_valid = 0;
        run_case("after_reset_57600", 17, 1'b0, 4);

        check("strobe_while_busy", pulse_busy_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_autobaud_detector.md
# uart_autobaud_detector

Measures the bit period of an incoming UART calibration character (0x55, 8N1, LSB first) on the serial line. Classifies it as one of the six supported baud rates and outputs the matching 3-bit baud-mode code, which drives the UART baud-mode select. Sits on the RX pin, ahead of the receive path, and runs from the system clock.

## Interface
- SYS_CLOCK, 100_000_000, system clock frequency in Hz; all nominal periods are derived from it at elaboration.
- Clk_In  input  1  system clock; all logic on posedge.
- Reset_In  input  1  reset, asynchronous, active-high.
- RX_In  input  1  asynchronous serial line, idle high.
- Detect_Start_In  input  1  one-cycle pulse that arms a detection.
- Baud_Rate_Mode_Out  output  3  detected mode:
  - 000=4800, 001=9600, 010=19200, 011=38400, 100=57600, 101=115200.
- Mode_Valid_Out  output  1  high while Baud_Rate_Mode_Out holds a successful detection.
- Busy_Out  output  1  high from arm until done or error.
- Done_Out  output  1  one-cycle pulse on successful detection.
- Error_Out  output  1  one-cycle pulse on failed detection.

## Operation
- RX_In passes through a 2-FF synchronizer. A falling edge is prev=1 and cur=0 on the synchronized signal.
- Nominal periods P_r = SYS_CLOCK / r, integer division. At 100 MHz: 20833, 10416, 5208, 2604, 1736, 868.
- FSM states:
  - IDLE: Detect_Start_In=1 → WAIT_EDGE.
  - WAIT_EDGE: first falling edge → MEASURE. Span counter (32 bit) cleared, edge count = 1.
  - MEASURE: Span increments every cycle. Each falling edge increments the edge count. On the 5th edge → CLASSIFY with Span = clocks between edge 1 and edge 5 (8 bit periods).
  - CLASSIFY: one cycle. Period = Span >> 3, then go to IDLE.
- Timeout: in MEASURE, if Span reaches 9*P_4800 → Error_Out pulse, then IDLE.
- WAIT_EDGE has no timeout; it waits indefinitely.
- Range check in CLASSIFY:
  - Period < P_115200 - P_115200/8, or Period > P_4800 + P_4800/8 → Error_Out pulse.
  - On error, Baud_Rate_Mode_Out and Mode_Valid_Out are unchanged.
- Classification picks the nearest nominal rate. Thresholds are midpoints (P_i + P_i+1)/2 between adjacent rates. Period equal to a threshold selects the slower rate.
- On success: register the mode, set Mode_Valid_Out=1, pulse Done_Out.
- Detect_Start_In:
  - Ignored when not in IDLE.
  - In IDLE it clears Mode_Valid_Out; Baud_Rate_Mode_Out keeps its old value.

## Timing
- Reset values: Baud_Rate_Mode_Out=101, Mode_Valid_Out=0, Busy_Out=0, Done_Out=0, Error_Out=0. FSM=IDLE, synchronizer regs=1.
- Busy_Out rises the cycle after Detect_Start_In. It falls in the same cycle that Done_Out or Error_Out is asserted.
- Edge latency: an RX_In fall before clock edge n is flagged at edge n+2 (n+3 with the filter enabled).
- Done_Out and Mode_Valid_Out assert one cycle after the 5th falling edge is flagged, i.e. the CLASSIFY cycle output registered.
- Reset asserted mid-measurement aborts immediately to reset values; no Done_Out or Error_Out is emitted.
- A falling edge in the same cycle that Span hits the timeout: the timeout wins.

## Configuration
- AUTOBAUD_GLITCH_FILTER_EN defined:
  - A 3-tap majority filter follows the synchronizer, adding 1 cycle of latency.
  - Low or high pulses of 1 clock are suppressed; edges are detected on the filtered line.
- Not defined: edges are detected directly on the synchronizer output, and every 1-cycle glitch counts as an edge.

## Test plan
- SYS_CLOCK=100e6, arm, send 0x55 at 10417 clk/bit → Done_Out pulse, Baud_Rate_Mode_Out=001, Mode_Valid_Out=1.
- Send 0x55 at 868 clk/bit, then at 20833 clk/bit → modes 101, then 000. Each run asserts Done_Out once.
- Arm, drive one falling edge, then hold RX_In low → Error_Out exactly 187497 cycles after the first flagged edge. Mode unchanged; Mode_Valid_Out=0.
- Send 0x55 at 700 clk/bit (Period 700 < 760) → Error_Out, mode unchanged.
- Single-cycle low glitch 1000 cycles before a 9600 frame:
  - With the macro defined → mode 001.
  - Without the macro → Error_Out, or a mode other than 001.
- Assert Reset_In after the 3rd edge → all outputs at reset values; a subsequent arm plus 57600 frame (1736 clk/bit) → mode 100.
